// File: rtl/router_pkg.sv
// Shared types and constants for the router output buffers.
package router_pkg;

  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_ADDR_W = 4;
  localparam int PKT_CNT_W   = 7;

  // One stored entry: header flag plus payload byte.
  typedef struct packed {
    logic       hdr;
    logic [7:0] data;
  } fifo_word_t;

  // Bytes still to read after a header: payload length (header[7:2]) plus parity.
  function automatic logic [PKT_CNT_W-1:0] pktLen(input logic [7:0] hdrByte);
    return PKT_CNT_W'(hdrByte[7:2]) + PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo_ram.sv
// Storage array for router_fifo: synchronous write, combinational read,
// asynchronous clear of every entry on reset.
module router_fifo_ram
  import router_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int WORD_W = 9,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [WORD_W-1:0] i_wrData,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [WORD_W-1:0] o_rdData
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Clear all entries on reset; otherwise store the incoming word at the write address.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/router_fifo.sv
// Output buffer for one destination port of the 1x3 router.
// Tracks packet boundaries via a per-entry header flag so data_out idles
// once a packet's parity byte has been presented.
// Optional build macro ROUTER_FIFO_TRISTATE_EN: idle data_out is all z
// instead of all zeros, for a shared output bus.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

`ifdef ROUTER_FIFO_TRISTATE_EN
  localparam logic [DATA_W-1:0] IDLE_VAL = {DATA_W{1'bz}};
`else
  localparam logic [DATA_W-1:0] IDLE_VAL = '0;
`endif

  logic [PTR_W-1:0]     r_wrPtr;
  logic [PTR_W-1:0]     r_rdPtr;
  logic [PKT_CNT_W-1:0] r_pktCnt;
  logic [DATA_W-1:0]    r_dataOut;

  logic              w_wrFire;
  logic              w_rdFire;
  logic [DATA_W:0]   w_wrWord;
  logic [DATA_W:0]   w_rdWord;
  logic              w_rdHdr;
  logic [DATA_W-1:0] w_rdByte;

  assign full  = (r_wrPtr[ADDR_W-1:0] == r_rdPtr[ADDR_W-1:0]) &&
                 (r_wrPtr[ADDR_W] != r_rdPtr[ADDR_W]);
  assign empty = (r_wrPtr == r_rdPtr);

  // Soft reset wins over any coincident transfer; full/empty are pre-edge values.
  assign w_wrFire = write_enb && !full  && !soft_reset;
  assign w_rdFire = read_enb  && !empty && !soft_reset;

  assign w_wrWord = {lfd_state, data_in};
  assign w_rdHdr  = w_rdWord[DATA_W];
  assign w_rdByte = w_rdWord[DATA_W-1:0];

  router_fifo_ram #(
    .DEPTH  (DEPTH),
    .WORD_W (DATA_W + 1),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock    (clock),
    .resetn   (resetn),
    .i_wrEn   (w_wrFire),
    .i_wrAddr (r_wrPtr[ADDR_W-1:0]),
    .i_wrData (w_wrWord),
    .i_rdAddr (r_rdPtr[ADDR_W-1:0]),
    .o_rdData (w_rdWord)
  );

  // Advance each pointer on its transfer; soft reset rewinds both to entry 0.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (soft_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_wrFire) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_rdFire) r_rdPtr <= r_rdPtr + PTR_W'(1);
    end
  end

  // Count bytes left in the packet being read: reload on a header, count down otherwise.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      r_pktCnt <= '0;
    end else if (soft_reset) begin
      r_pktCnt <= '0;
    end else if (w_rdFire) begin
      if (w_rdHdr) begin
        r_pktCnt <= pktLen(w_rdByte[7:0]);
      end else if (r_pktCnt != '0) begin
        r_pktCnt <= r_pktCnt - PKT_CNT_W'(1);
      end
    end
  end

  // Registered read data: show the read byte, idle once the packet is exhausted, else hold.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      r_dataOut <= IDLE_VAL;
    end else if (soft_reset) begin
      r_dataOut <= IDLE_VAL;
    end else if (w_rdFire) begin
      r_dataOut <= w_rdByte;
    end else if (r_pktCnt == '0) begin
      r_dataOut <= IDLE_VAL;
    end
  end

  assign data_out = r_dataOut;

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo.
// Honours ROUTER_FIFO_TRISTATE_EN for the expected idle value.
module tb_router_fifo;

`ifdef ROUTER_FIFO_TRISTATE_EN
  localparam logic [7:0] IDLE = 8'bzzzz_zzzz;
`else
  localparam logic [7:0] IDLE = 8'h00;
`endif

  logic       clock;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int checkCount;
  int errorCount;

  router_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then settle 1 ns past it.
  task automatic applyStimulus(input logic we, input logic re, input logic lfd,
                               input logic [7:0] din, input logic srst);
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    soft_reset = srst;
    @(posedge clock);
    #1;
  endtask

  // Directed scenarios in sequence.
  initial begin
    checkCount = 0;
    errorCount = 0;
    resetn     = 1'b1;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b0;

    checkOutput("reset_empty", 32'(empty), 32'd1);
    checkOutput("reset_full", 32'(full), 32'd0);
    checkOutput("reset_dout", 32'(data_out), 32'(IDLE));

    // Packet round trip: header 0x0C announces 3 payload bytes plus parity.
    applyStimulus(1, 0, 1, 8'h0C, 0);
    checkOutput("rt_empty_after_write", 32'(empty), 32'd0);
    applyStimulus(1, 0, 0, 8'h11, 0);
    applyStimulus(1, 0, 0, 8'h22, 0);
    applyStimulus(1, 0, 0, 8'h33, 0);
    applyStimulus(1, 0, 0, 8'h2E, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    checkOutput("rt_hdr", 32'(data_out), 32'h0C);
    applyStimulus(0, 1, 0, 8'h00, 0);
    checkOutput("rt_b1", 32'(data_out), 32'h11);
    applyStimulus(0, 1, 0, 8'h00, 0);
    checkOutput("rt_b2", 32'(data_out), 32'h22);
    applyStimulus(0, 1, 0, 8'h00, 0);
    checkOutput("rt_b3", 32'(data_out), 32'h33);
    applyStimulus(0, 1, 0, 8'h00, 0);
    checkOutput("rt_parity", 32'(data_out), 32'h2E);
    checkOutput("rt_empty", 32'(empty), 32'd1);
    applyStimulus(0, 0, 0, 8'h00, 0);
    checkOutput("rt_idle", 32'(data_out), 32'(IDLE));

    // Reads while empty must not move the pointers or disturb the output.
    applyStimulus(0, 1, 0, 8'h00, 0);
    checkOutput("er_dout1", 32'(data_out), 32'(IDLE));
    applyStimulus(0, 1, 0, 8'h00, 0);
    checkOutput("er_dout2", 32'(data_out), 32'(IDLE));
    checkOutput("er_empty", 32'(empty), 32'd1);
    applyStimulus(1, 0, 0, 8'h5A, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    checkOutput("er_readback", 32'(data_out), 32'h5A);
    checkOutput("er_empty_after", 32'(empty), 32'd1);

    // Fill to 16, drop a 17th write, then read+write while full.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, 0, 8'(3 * i + 1), 0);
    end
    checkOutput("fu_full", 32'(full), 32'd1);
    checkOutput("fu_not_empty", 32'(empty), 32'd0);
    applyStimulus(1, 0, 0, 8'hFF, 0);
    checkOutput("fu_full_after_drop", 32'(full), 32'd1);
    applyStimulus(1, 1, 0, 8'hEE, 0);
    checkOutput("fu_rw_dout", 32'(data_out), 32'h01);
    checkOutput("fu_rw_full", 32'(full), 32'd0);
    for (int i = 1; i < 16; i++) begin
      applyStimulus(0, 1, 0, 8'h00, 0);
      checkOutput($sformatf("fu_drain_%0d", i), 32'(data_out), 32'(3 * i + 1));
    end
    checkOutput("fu_drained_empty", 32'(empty), 32'd1);

    // Soft reset after header + 1 byte of an 8-byte packet (header 0x18 = 6 payload).
    applyStimulus(1, 0, 1, 8'h18, 0);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1, 0, 0, 8'(8'h80 + i), 0);
    end
    applyStimulus(1, 0, 0, 8'h99, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    checkOutput("sr_hdr", 32'(data_out), 32'h18);
    applyStimulus(0, 1, 0, 8'h00, 0);
    checkOutput("sr_b1", 32'(data_out), 32'h81);
    applyStimulus(0, 1, 0, 8'h00, 1);
    checkOutput("sr_empty", 32'(empty), 32'd1);
    checkOutput("sr_full", 32'(full), 32'd0);
    checkOutput("sr_dout", 32'(data_out), 32'(IDLE));
    applyStimulus(1, 0, 1, 8'h42, 0);
    checkOutput("sr_new_write", 32'(empty), 32'd0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    checkOutput("sr_new_read", 32'(data_out), 32'h42);
    checkOutput("sr_new_empty", 32'(empty), 32'd1);
    applyStimulus(0, 0, 0, 8'h00, 0);
    checkOutput("sr_hold_midpkt", 32'(data_out), 32'h42);
    applyStimulus(0, 0, 0, 8'h00, 1);
    checkOutput("sr_flush_idle", 32'(data_out), 32'(IDLE));

    // Interleaved write/read pairs carry the pointers across the wrap.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 0, 8'(8'hA0 + i), 0);
      checkOutput($sformatf("wr_full_%0d", i), 32'(full), 32'd0);
      applyStimulus(0, 1, 0, 8'h00, 0);
      checkOutput($sformatf("wr_data_%0d", i), 32'(data_out), 32'(8'hA0 + i));
    end

    // Asynchronous reset asserted in the middle of a write cycle.
    applyStimulus(1, 0, 1, 8'h10, 0);
    applyStimulus(1, 0, 0, 8'h20, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    checkOutput("ar_pre_dout", 32'(data_out), 32'h10);
    write_enb = 1'b1;
    data_in   = 8'h30;
    #3;
    resetn = 1'b1;
    #1;
    checkOutput("ar_empty", 32'(empty), 32'd1);
    checkOutput("ar_full", 32'(full), 32'd0);
    checkOutput("ar_dout", 32'(data_out), 32'(IDLE));
    write_enb = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b0;
    applyStimulus(0, 1, 0, 8'h00, 0);
    checkOutput("ar_post_empty", 32'(empty), 32'd1);
    checkOutput("ar_post_dout", 32'(data_out), 32'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
